// File: rtl/pool_2d_stream_pkg.sv
// Shared sizes, pooling-mode and FSM encodings, and small helpers for the 2-D pooling stage.
package pool_2d_stream_pkg;

   localparam int DESIGN_SIZE   = 16;
   localparam int DWIDTH        = 8;
   localparam int MAX_BITS_POOL = 3;
   localparam int MASK_WIDTH    = DESIGN_SIZE;
   localparam int ROW_CNT_BITS  = 8;

   // Horizontal group sum (up to 4 lanes) and vertical accumulator widths.
   localparam int S1W  = DWIDTH + 2;
   localparam int ACCW = DWIDTH + 4;

   localparam logic POOL_MODE_AVG = 1'b0;
   localparam logic POOL_MODE_MAX = 1'b1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic logic win_legal(input logic [MAX_BITS_POOL-1:0] w);
      return (w == MAX_BITS_POOL'(1)) || (w == MAX_BITS_POOL'(2)) || (w == MAX_BITS_POOL'(4));
   endfunction

   // Illegal window sizes collapse to W = 1 (log2 = 0).
   function automatic logic [1:0] win_log2(input logic [MAX_BITS_POOL-1:0] w);
      logic [1:0] l;
      case (w)
         MAX_BITS_POOL'(2): l = 2'd1;
         MAX_BITS_POOL'(4): l = 2'd2;
         default:           l = 2'd0;
      endcase
      return l;
   endfunction

   function automatic logic [DWIDTH-1:0] max_lane(input logic [DWIDTH-1:0] a,
                                                  input logic [DWIDTH-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_row_reduce.sv
// Combinational horizontal reducer: masks lanes, then sums or maxes each group of W adjacent lanes.
module pool_row_reduce
   import pool_2d_stream_pkg::*;
(
   input  logic [DESIGN_SIZE*DWIDTH-1:0] row_data,
   input  logic [MASK_WIDTH-1:0]         lane_mask,
   input  logic                          mode_max,
   input  logic [1:0]                    wlog2,
   output logic [DESIGN_SIZE*S1W-1:0]    group_out
);

   logic [DESIGN_SIZE-1:0][DWIDTH-1:0] lane_m;

   genvar gi;
   generate
      for (gi = 0; gi < DESIGN_SIZE; gi++) begin : g_mask
         assign lane_m[gi] = lane_mask[gi] ? row_data[gi*DWIDTH +: DWIDTH] : '0;
      end

      // Groups that do not exist for the current W produce 0, so unused output lanes stay 0.
      for (gi = 0; gi < DESIGN_SIZE; gi++) begin : g_grp
         logic [S1W-1:0] v1, v2, v4;

         assign v1 = S1W'(lane_m[gi]);

         if (gi < DESIGN_SIZE/2) begin : g_w2
            assign v2 = mode_max ? S1W'(max_lane(lane_m[2*gi], lane_m[2*gi+1]))
                                 : S1W'(lane_m[2*gi]) + S1W'(lane_m[2*gi+1]);
         end else begin : g_w2_off
            assign v2 = '0;
         end

         if (gi < DESIGN_SIZE/4) begin : g_w4
            assign v4 = mode_max ? S1W'(max_lane(max_lane(lane_m[4*gi],   lane_m[4*gi+1]),
                                                 max_lane(lane_m[4*gi+2], lane_m[4*gi+3])))
                                 : S1W'(lane_m[4*gi])   + S1W'(lane_m[4*gi+1])
                                 + S1W'(lane_m[4*gi+2]) + S1W'(lane_m[4*gi+3]);
         end else begin : g_w4_off
            assign v4 = '0;
         end

         assign group_out[gi*S1W +: S1W] = (wlog2 == 2'd2) ? v4 :
                                           (wlog2 == 2'd1) ? v2 : v1;
      end
   endgenerate

endmodule

// File: rtl/pool_2d_stream.sv
// Streaming WxW average/max pooling: horizontal reduce (stage 1), vertical accumulate (stage 2),
// partial-window flush at tile end, registered bypass when disabled.
module pool_2d_stream
   import pool_2d_stream_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable_pool,
   input  logic                          pool_mode,
   input  logic [MAX_BITS_POOL-1:0]      pool_window_size,
   input  logic [ROW_CNT_BITS-1:0]       num_rows,
   input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
   input  logic                          in_data_available,
   input  logic [MASK_WIDTH-1:0]         validity_mask,
   output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
   output logic                          out_data_available,
   output logic                          done_pool,
   output logic                          pool_cfg_err
);

   logic [1:0]                    state_reg;
   logic                          mode_reg;
   logic [1:0]                    wlog2_reg;
   logic [ROW_CNT_BITS-1:0]       rows_reg, row_cnt_reg;
   logic                          cfg_err_reg, done_reg;
   logic [DESIGN_SIZE*S1W-1:0]    s1_reg, red_out;
   logic                          s1_valid_reg, s1_last_reg;
   logic [1:0]                    wc_reg;
   logic [DESIGN_SIZE*DWIDTH-1:0] out_reg, out_next;
   logic                          out_valid_reg, out_last_reg;

   logic                          in_idle, beat_ok, accept, is_last_row, cur_mode, win_close;
   logic [1:0]                    cur_wlog2, wc_max;
   logic [ROW_CNT_BITS-1:0]       cur_rows, row_cnt_inc;

   // The first beat of a tile is reduced with the live config, later beats with the latched one.
   assign in_idle     = (state_reg == ST_IDLE);
   assign cur_mode    = in_idle ? pool_mode : mode_reg;
   assign cur_wlog2   = in_idle ? win_log2(pool_window_size) : wlog2_reg;
   assign cur_rows    = in_idle ? num_rows : rows_reg;
   assign row_cnt_inc = row_cnt_reg + ROW_CNT_BITS'(1);
   assign is_last_row = (row_cnt_inc == cur_rows);
   assign beat_ok     = in_data_available && (in_idle || state_reg == ST_ACCUM);
   assign accept      = beat_ok && !(in_idle && num_rows == '0);

   // W-1 for W in {1,2,4}; the tile's last beat also closes a (possibly partial) window.
   assign wc_max    = (wlog2_reg == 2'd2) ? 2'd3 : wlog2_reg;
   assign win_close = s1_valid_reg && ((wc_reg == wc_max) || s1_last_reg);

   pool_row_reduce u_reduce (
      .row_data  (inp_data),
      .lane_mask (validity_mask),
      .mode_max  (cur_mode),
      .wlog2     (cur_wlog2),
      .group_out (red_out)
   );

   genvar gi;
   generate
      for (gi = 0; gi < DESIGN_SIZE; gi++) begin : g_lane
         logic [ACCW-1:0] acc_reg, acc_next, s1_ext;

         assign s1_ext = ACCW'(s1_reg[gi*S1W +: S1W]);

         always_comb begin
            acc_next = acc_reg;
            if (s1_valid_reg) begin
               if (wc_reg == 2'd0)
                  acc_next = s1_ext;
               else if (mode_reg == POOL_MODE_MAX)
                  acc_next = (s1_ext > acc_reg) ? s1_ext : acc_reg;
               else
                  acc_next = acc_reg + s1_ext;
            end
         end

         always_ff @(posedge clk) begin
            if (reset || !enable_pool)
               acc_reg <= '0;
            else
               acc_reg <= acc_next;
         end

         // Average divides by W*W even for a partial window, i.e. zero padding.
         assign out_next[gi*DWIDTH +: DWIDTH] = (mode_reg == POOL_MODE_AVG)
                                              ? DWIDTH'(acc_next >> {wlog2_reg, 1'b0})
                                              : acc_next[DWIDTH-1:0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         mode_reg      <= POOL_MODE_AVG;
         wlog2_reg     <= '0;
         rows_reg      <= '0;
         row_cnt_reg   <= '0;
         cfg_err_reg   <= 1'b0;
         done_reg      <= 1'b0;
         s1_reg        <= '0;
         s1_valid_reg  <= 1'b0;
         s1_last_reg   <= 1'b0;
         wc_reg        <= '0;
         out_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
      end else if (!enable_pool) begin
         state_reg     <= ST_IDLE;
         row_cnt_reg   <= '0;
         s1_valid_reg  <= 1'b0;
         s1_last_reg   <= 1'b0;
         wc_reg        <= '0;
         out_reg       <= inp_data;
         out_valid_reg <= in_data_available;
         out_last_reg  <= 1'b0;
         done_reg      <= 1'b1;
      end else begin
         s1_valid_reg <= accept;
         if (accept) begin
            s1_reg      <= red_out;
            s1_last_reg <= is_last_row;
         end
         if (s1_valid_reg)
            wc_reg <= win_close ? 2'd0 : wc_reg + 2'd1;
         out_valid_reg <= win_close;
         out_last_reg  <= win_close && s1_last_reg;
         if (win_close)
            out_reg <= out_next;

         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (beat_ok) begin
                  mode_reg  <= pool_mode;
                  wlog2_reg <= win_log2(pool_window_size);
                  rows_reg  <= num_rows;
                  if (!win_legal(pool_window_size) || num_rows == '0)
                     cfg_err_reg <= 1'b1;
                  if (num_rows == '0) begin
                     state_reg <= ST_DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     row_cnt_reg <= row_cnt_inc;
                     state_reg   <= is_last_row ? ST_FLUSH : ST_ACCUM;
                  end
               end
            end
            ST_ACCUM: begin
               if (accept) begin
                  row_cnt_reg <= row_cnt_inc;
                  if (is_last_row)
                     state_reg <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (out_last_reg) begin
                  state_reg <= ST_DONE;
                  done_reg  <= 1'b1;
               end
            end
            default: done_reg <= 1'b1;
         endcase
      end
   end

   assign out_data           = out_reg;
   assign out_data_available = out_valid_reg;
   assign done_pool          = done_reg;
   assign pool_cfg_err       = cfg_err_reg;

endmodule

// File: tb/tb_pool_2d_stream.sv
// Bench for pool_2d_stream: window-level pooling model plus a per-cycle output scoreboard.
module tb_pool_2d_stream;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable_pool;
   logic         pool_mode;
   logic [2:0]   pool_window_size;
   logic [7:0]   num_rows;
   logic [127:0] inp_data;
   logic         in_data_available;
   logic [15:0]  validity_mask;
   logic [127:0] out_data;
   logic         out_data_available;
   logic         done_pool;
   logic         pool_cfg_err;

   pool_2d_stream dut (
      .clk                (clk),
      .reset              (reset),
      .enable_pool        (enable_pool),
      .pool_mode          (pool_mode),
      .pool_window_size   (pool_window_size),
      .num_rows           (num_rows),
      .inp_data           (inp_data),
      .in_data_available  (in_data_available),
      .validity_mask      (validity_mask),
      .out_data           (out_data),
      .out_data_available (out_data_available),
      .done_pool          (done_pool),
      .pool_cfg_err       (pool_cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           t;
      logic [127:0] d;
   } exp_t;

   exp_t         expq[$];
   int           cyc = 0;
   int           n_checks = 0;
   int           n_fail = 0;
   int           n_pulses = 0;
   bit           chk_en = 1'b0;
   logic         exp_err = 1'b0;
   logic [127:0] seen_data = '0;
   logic [7:0]   rows_m [256][16];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
      end
   endtask

   // Scoreboard: a pulse exactly when one is scheduled, with the scheduled data.
   always @(negedge clk) begin
      if (chk_en) begin
         if (expq.size() > 0 && expq[0].t == cyc) begin
            check("pulse_valid", 128'(out_data_available), 128'd1);
            check("pulse_data", out_data, expq[0].d);
            void'(expq.pop_front());
         end else begin
            check("no_pulse", 128'(out_data_available), 128'd0);
         end
         if (out_data_available === 1'b1) begin
            seen_data = out_data;
            n_pulses++;
         end
      end
   end

   // Pool rows r0..r1-1 (already masked) as one window; avg divides by the full W*W.
   function automatic logic [127:0] model_window(input int r0, input int r1, input int w, input logic mode);
      logic [127:0] res;
      int acc;
      res = '0;
      for (int j = 0; j < 16 / w; j++) begin
         acc = 0;
         for (int r = r0; r < r1; r++)
            for (int k = j * w; k < j * w + w; k++)
               if (mode) acc = (int'(rows_m[r][k]) > acc) ? int'(rows_m[r][k]) : acc;
               else      acc += int'(rows_m[r][k]);
         if (!mode) acc = acc / (w * w);
         res[j*8 +: 8] = 8'(acc);
      end
      return res;
   endfunction

   function automatic logic [7:0] pat_val(input int pat, input int r, input int k, input logic [7:0] cval);
      case (pat)
         0:       return 8'($urandom);
         1:       return (r == 0 && k == 0) ? 8'd8 : 8'd4;
         2:       return 8'(r * 16 + k);
         default: return cval;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_tile(input logic mode, input int wraw, input int nrows, input int pat,
                           input logic [7:0] cval, input logic [15:0] mask_fix, input bit rand_mask,
                           input int gap_at, input int gap_pct);
      int w, r, wstart;
      bit gapped;
      logic [127:0] d;
      logic [15:0] m;
      w = (wraw == 1 || wraw == 2 || wraw == 4) ? wraw : 1;
      if (w != wraw) exp_err = 1'b1;
      r = 0; wstart = 0; gapped = 1'b0;
      pool_mode = mode; pool_window_size = 3'(wraw); num_rows = 8'(nrows);
      while (r < nrows) begin
         step();
         if (r > 0) begin
            // Config must be latched on the first beat; scramble it afterwards.
            pool_mode = 1'($urandom); pool_window_size = 3'($urandom); num_rows = 8'($urandom);
         end
         if (r == gap_at && !gapped) begin
            in_data_available = 1'b0;
            inp_data = {$urandom, $urandom, $urandom, $urandom};
            repeat (2) step();
            gapped = 1'b1;
            continue;
         end
         if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            in_data_available = 1'b0;
            inp_data = {$urandom, $urandom, $urandom, $urandom};
            continue;
         end
         for (int k = 0; k < 16; k++) d[k*8 +: 8] = pat_val(pat, r, k, cval);
         m = rand_mask ? 16'($urandom) : mask_fix;
         inp_data = d; validity_mask = m; in_data_available = 1'b1;
         for (int k = 0; k < 16; k++) rows_m[r][k] = m[k] ? d[k*8 +: 8] : 8'd0;
         r++;
         if (r - wstart == w || r == nrows) begin
            expq.push_back('{cyc + 2, model_window(wstart, r, w, mode)});
            wstart = r;
         end
      end
      step();
      inp_data = {$urandom, $urandom, $urandom, $urandom};
      in_data_available = 1'b1;
      @(negedge clk);
      step();
      in_data_available = 1'b0;
      @(negedge clk);
      check("done_low_at_last_pulse", 128'(done_pool), 128'd0);
      @(negedge clk);
      check("done_after_last_pulse", 128'(done_pool), 128'd1);
      check("cfg_err", 128'(pool_cfg_err), 128'(exp_err));
   endtask

   task automatic end_tile();
      step();
      enable_pool = 1'b0; in_data_available = 1'b0;
      step();
      enable_pool = 1'b1;
      step();
      @(negedge clk);
      check("done_clear", 128'(done_pool), 128'd0);
   endtask

   initial begin
      int n0, wraw;
      int wtab[5];
      wtab = '{1, 2, 4, 3, 0};
      reset = 1'b1; enable_pool = 1'b1; pool_mode = 1'b0; pool_window_size = 3'd1;
      num_rows = 8'd1; inp_data = '0; in_data_available = 1'b0; validity_mask = 16'hFFFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_data", out_data, 128'd0);
      check("reset_out_avail", 128'(out_data_available), 128'd0);
      check("reset_done", 128'(done_pool), 128'd0);
      check("reset_cfg_err", 128'(pool_cfg_err), 128'd0);
      chk_en = 1'b1;
      step();
      reset = 1'b0;

      // T1: avg W=2, two rows.
      run_tile(1'b0, 2, 2, 1, 8'd0, 16'hFFFF, 1'b0, -1, 0);
      check("t1_literal", seen_data, 128'h0000_0000_0000_0000_0404_0404_0404_0405);
      end_tile();

      // T2: max W=4, four rows of r*16+k.
      run_tile(1'b1, 4, 4, 2, 8'd0, 16'hFFFF, 1'b0, -1, 0);
      check("t2_literal", seen_data, 128'h0000_0000_0000_0000_0000_0000_3F3B_3733);
      end_tile();

      // T3: avg W=2, three rows: one full window then a zero-padded flush.
      n0 = n_pulses;
      run_tile(1'b0, 2, 3, 3, 8'd200, 16'hFFFF, 1'b0, -1, 0);
      check("t3_pulse_count", 128'(n_pulses - n0), 128'd2);
      check("t3_flush_literal", seen_data, 128'h0000_0000_0000_0000_6464_6464_6464_6464);
      end_tile();

      // T4: masked max W=1 with three idle cycles mid-tile.
      n0 = n_pulses;
      run_tile(1'b1, 1, 4, 3, 8'd9, 16'h00FF, 1'b0, 2, 0);
      check("t4_pulse_count", 128'(n_pulses - n0), 128'd4);
      check("t4_literal", seen_data, 128'h0000_0000_0000_0000_0909_0909_0909_0909);
      end_tile();

      // T5: illegal W=3 behaves as W=1 and flags an error.
      n0 = n_pulses;
      run_tile(1'b0, 3, 2, 0, 8'd0, 16'hFFFF, 1'b1, -1, 0);
      check("t5_pulse_count", 128'(n_pulses - n0), 128'd2);
      end_tile();

      // T5b: reset during the second beat aborts the tile with no output.
      step(); reset = 1'b1;
      step(); reset = 1'b0; exp_err = 1'b0;
      pool_mode = 1'b0; pool_window_size = 3'd3; num_rows = 8'd2; validity_mask = 16'hFFFF;
      step(); inp_data = {$urandom, $urandom, $urandom, $urandom}; in_data_available = 1'b1;
      step(); inp_data = {$urandom, $urandom, $urandom, $urandom}; reset = 1'b1;
      step(); reset = 1'b0; in_data_available = 1'b0;
      @(negedge clk);
      check("t5b_out_data", out_data, 128'd0);
      check("t5b_out_avail", 128'(out_data_available), 128'd0);
      check("t5b_done", 128'(done_pool), 128'd0);
      check("t5b_cfg_err", 128'(pool_cfg_err), 128'd0);
      repeat (5) step();

      // num_rows = 0 goes straight to done and flags an error.
      pool_window_size = 3'd2; num_rows = 8'd0;
      step(); in_data_available = 1'b1;
      step(); in_data_available = 1'b0;
      @(negedge clk);
      exp_err = 1'b1;
      check("rows0_done", 128'(done_pool), 128'd1);
      check("rows0_cfg_err", 128'(pool_cfg_err), 128'd1);
      end_tile();

      // Randomized tiles with gaps, masks and all window sizes.
      for (int t = 0; t < 30; t++) begin
         wraw = wtab[$urandom_range(0, 4)];
         run_tile(1'($urandom), wraw, int'($urandom_range(1, 9)), 0, 8'd0, 16'hFFFF, 1'b1, -1, 20);
         end_tile();
      end

      // T6: bypass.
      step();
      enable_pool = 1'b0; inp_data = {16{8'hA5}}; in_data_available = 1'b1;
      expq.push_back('{cyc + 1, {16{8'hA5}}});
      step();
      in_data_available = 1'b0; inp_data = '0;
      @(negedge clk);
      check("t6_out_data", out_data, {16{8'hA5}});
      check("t6_out_avail", 128'(out_data_available), 128'd1);
      check("t6_done", 128'(done_pool), 128'd1);
      @(negedge clk);
      check("t6_done_hold", 128'(done_pool), 128'd1);
      check("t6_avail_drop", 128'(out_data_available), 128'd0);
      check("t6_cfg_err_hold", 128'(pool_cfg_err), 128'(exp_err));
      repeat (3) step();

      check("queue_drained", 128'(expq.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
